// File: rtl/buck_pwm_ctrl_if.sv
// Control/status bundle between the buck PWM controller and the converter model.
// Master drives enable and sampled codes; slave returns gate drive and status.
`timescale 1ns/1ps
interface buck_pwm_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
);
  logic                     en;
  logic signed [DATA_W-1:0] v_out;
  logic signed [DATA_W-1:0] i_mag;
  logic                     gate;
  logic [CNT_W-1:0]         duty;
  logic [1:0]               state;
  logic                     fault;

  modport master (output en, v_out, i_mag, input gate, duty, state, fault);
  modport slave  (input en, v_out, i_mag, output gate, duty, state, fault);
endinterface

// File: rtl/buck_pwm_ctrl.sv
// Closed-loop buck PWM controller: soft-start, integral duty regulation per period,
// cycle-by-cycle over-current cutoff and a latched fault after persistent over-current.
`timescale 1ns/1ps
module buck_pwm_ctrl #(
  parameter int unsigned              PERIOD_CYCLES = 200,
  parameter int unsigned              CNT_W         = 8,
  parameter int unsigned              DATA_W        = 16,
  parameter logic signed [DATA_W-1:0] V_REF         = 16'sd2500,
  parameter logic signed [DATA_W-1:0] I_LIM         = 16'sd4000,
  parameter int unsigned              DUTY_MAX      = 180,
  parameter int unsigned              SS_STEP       = 2,
  parameter int unsigned              KI_SHIFT      = 6,
  parameter int unsigned              FAULT_PERIODS = 4
) (
  input  logic             clk,
  input  logic             rst,
  buck_pwm_ctrl_if.slave   bus
);

  localparam int unsigned OC_W  = $clog2(FAULT_PERIODS + 1);
  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned ERR_W = DATA_W + 1;
  localparam int unsigned SUM_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX_C = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] SS_STEP_C  = CNT_W'(SS_STEP);
  localparam logic [OC_W-1:0]  OC_LAST    = OC_W'(FAULT_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SOFT  = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_duty, w_duty_nxt;
  logic              r_trip, w_trip_nxt;
  logic [OC_W-1:0]   r_oc_cnt, w_oc_nxt;

  logic                    w_active, w_gate, w_period_end, w_trip_set, w_trip_any;
  logic [CW1-1:0]          w_ss_sum;
  logic                    w_ss_sat, w_ss_done;
  logic [CNT_W-1:0]        w_ss_duty;
  logic signed [ERR_W-1:0] w_err, w_delta;
  logic [SUM_W-1:0]        w_run_sum;
  logic [CNT_W-1:0]        w_run_duty;

  // Gate is a pure decode of registered state so inputs never reach the switch directly
  assign w_active     = (r_state == S_SOFT) || (r_state == S_RUN);
  assign w_gate       = w_active && (r_cnt < r_duty) && !r_trip;
  assign w_period_end = (r_cnt == CNT_LAST);
  assign w_trip_set   = w_gate && (bus.i_mag > I_LIM);
  assign w_trip_any   = r_trip || w_trip_set;

  assign w_ss_sum  = {1'b0, r_duty} + {1'b0, SS_STEP_C};
  assign w_ss_sat  = (w_ss_sum >= CW1'(DUTY_MAX));
  assign w_ss_done = (bus.v_out >= V_REF) || w_ss_sat;
  assign w_ss_duty = w_ss_sat ? DUTY_MAX_C : w_ss_sum[CNT_W-1:0];

  // Integral step: floor((V_REF - v_out) / 2^KI_SHIFT), clamped to [0, DUTY_MAX]
  assign w_err     = {V_REF[DATA_W-1], V_REF} - {bus.v_out[DATA_W-1], bus.v_out};
  assign w_delta   = w_err >>> KI_SHIFT;
  assign w_run_sum = {{(SUM_W-CNT_W){1'b0}}, r_duty} + {{(SUM_W-ERR_W){w_delta[ERR_W-1]}}, w_delta};
  assign w_run_duty = w_run_sum[SUM_W-1]                ? '0 :
                      (w_run_sum > SUM_W'(DUTY_MAX))    ? DUTY_MAX_C :
                                                          w_run_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_duty   <= '0;
      r_trip   <= 1'b0;
      r_oc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_duty   <= w_duty_nxt;
      r_trip   <= w_trip_nxt;
      r_oc_cnt <= w_oc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_duty_nxt  = r_duty;
    w_trip_nxt  = r_trip;
    w_oc_nxt    = r_oc_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_duty_nxt = '0;
        w_trip_nxt = 1'b0;
        w_oc_nxt   = '0;
        if (bus.en) begin
          w_state_nxt = S_SOFT;
          w_duty_nxt  = SS_STEP_C;
        end
      end
      S_SOFT, S_RUN: begin
        if (!bus.en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_duty_nxt  = '0;
          w_trip_nxt  = 1'b0;
          w_oc_nxt    = '0;
        end else if (w_period_end) begin
          // A trip landing on the period-end edge still counts for the ending period
          w_cnt_nxt  = '0;
          w_trip_nxt = 1'b0;
          w_oc_nxt   = w_trip_any ? (r_oc_cnt + OC_W'(1)) : '0;
          if (w_trip_any && (r_oc_cnt == OC_LAST)) begin
            w_state_nxt = S_FAULT;
            w_duty_nxt  = '0;
            w_oc_nxt    = '0;
          end else if (r_state == S_SOFT) begin
            w_duty_nxt = w_ss_duty;
            if (w_ss_done) w_state_nxt = S_RUN;
          end else begin
            w_duty_nxt = w_run_duty;
          end
        end else begin
          w_cnt_nxt  = r_cnt + CNT_W'(1);
          w_trip_nxt = w_trip_any;
        end
      end
      S_FAULT: begin
        w_cnt_nxt  = '0;
        w_duty_nxt = '0;
        w_trip_nxt = 1'b0;
        w_oc_nxt   = '0;
        if (!bus.en) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.gate  = w_gate;
  assign bus.duty  = r_duty;
  assign bus.state = r_state;
  assign bus.fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Self-checking bench for buck_pwm_ctrl: per-period pulse width, duty and state
// expectations are queued before each period and compared when it completes.
`timescale 1ns/1ps
module tb_buck_pwm_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buck_pwm_ctrl_if #(.DATA_W(16), .CNT_W(8)) bus ();

  buck_pwm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   i_hi     = 0;

  // RUN-mode regulation table: v_out applied for one period and the duty it must produce
  int tbl_v[11] = '{7620, 2500, 2180, 2820, 2564, -2556, 0, 32767, -3900, 2501, 2436};
  int tbl_d[11] = '{ 100,  100,  105,  100,   99,   178, 180,    0,   100,   99,  100};

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got %0d expected none queued", got);
    end else begin
      e = sb_q.pop_front();
      chk_eq(e.tag, got, e.val);
    end
  endtask

  // One full PWM period starting at cnt=0; i_mag goes to i_hi at sample ion and 0 at ioff
  task automatic do_period(input int ion, input int ioff, input int exp_pulse,
                           input int exp_duty, input int exp_state);
    int hi;
    sb_q.push_back('{"pulse", exp_pulse});
    sb_q.push_back('{"duty", exp_duty});
    sb_q.push_back('{"state", exp_state});
    hi = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == ion)  bus.i_mag = 16'(i_hi);
      if (k == ioff) bus.i_mag = 16'sd0;
      hi += int'(bus.gate);
      tick();
    end
    sb_pop(hi);
    sb_pop(int'(bus.duty));
    sb_pop(int'(bus.state));
  endtask

  initial begin
    int d, nd, ns, bad;
    bit run;

    rst       = 1'b0;
    bus.en    = 1'b0;
    bus.v_out = 16'sd0;
    bus.i_mag = 16'sd0;
    repeat (3) tick();
    chk_eq("rst_gate", int'(bus.gate), 0);
    chk_eq("rst_duty", int'(bus.duty), 0);
    chk_eq("rst_state", int'(bus.state), 0);
    chk_eq("rst_fault", int'(bus.fault), 0);

    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (bus.gate || bus.state != 2'd0 || bus.duty != 8'd0 || bus.fault) bad++;
    end
    chk_eq("idle_hold_bad_cycles", bad, 0);

    // Soft-start ramp with v_out held at 0
    bus.en = 1'b1;
    tick();
    chk_eq("ss_entry_state", int'(bus.state), 1);
    chk_eq("ss_entry_duty", int'(bus.duty), 2);
    d   = 2;
    run = 1'b0;
    while (!run) begin
      nd = d + 2;
      ns = 1;
      if (nd >= 180) begin
        nd  = 180;
        ns  = 2;
        run = 1'b1;
      end
      do_period(-1, -1, d, nd, ns);
      d = nd;
    end

    // Integral regulation in RUN
    for (int i = 0; i < 11; i++) begin
      bus.v_out = 16'(tbl_v[i]);
      do_period(-1, -1, d, tbl_d[i], 2);
      d = tbl_d[i];
    end

    // Cycle-by-cycle cutoff at cnt=40, then recovery and the non-tripping limit value
    bus.v_out = 16'sd2500;
    i_hi      = 4001;
    do_period(40, 60, 41, 100, 2);
    do_period(-1, -1, 100, 100, 2);
    bus.i_mag = 16'sd4000;
    do_period(-1, -1, 100, 100, 2);
    bus.i_mag = 16'sd0;

    // Persistent over-current latches FAULT on the fourth tripped period
    i_hi = 5000;
    do_period(0, -1, 1, 100, 2);
    do_period(-1, -1, 1, 100, 2);
    do_period(-1, -1, 1, 100, 2);
    do_period(-1, -1, 1, 0, 3);
    chk_eq("fault_flag", int'(bus.fault), 1);
    chk_eq("fault_gate", int'(bus.gate), 0);

    // en glitch between edges must not release the latch
    bus.en = 1'b0;
    #3;
    bus.en    = 1'b1;
    bus.i_mag = 16'sd0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.state != 2'd3 || bus.gate || !bus.fault || bus.duty != 8'd0) bad++;
    end
    chk_eq("fault_latched_bad_cycles", bad, 0);
    bus.en = 1'b0;
    tick();
    chk_eq("fault_release_state", int'(bus.state), 0);
    chk_eq("fault_release_flag", int'(bus.fault), 0);
    bus.en = 1'b1;
    tick();
    chk_eq("restart_state", int'(bus.state), 1);
    chk_eq("restart_duty", int'(bus.duty), 2);

    // Mid-period reset while the gate is high
    bus.v_out = 16'sd2500;
    do_period(-1, -1, 2, 4, 2);
    bus.v_out = -16'sd3900;
    do_period(-1, -1, 4, 104, 2);
    repeat (77) tick();
    chk_eq("pre_rst_gate", int'(bus.gate), 1);
    rst = 1'b0;
    tick();
    chk_eq("midrst_gate", int'(bus.gate), 0);
    chk_eq("midrst_duty", int'(bus.duty), 0);
    chk_eq("midrst_state", int'(bus.state), 0);
    rst = 1'b1;
    tick();
    chk_eq("post_rst_state", int'(bus.state), 1);
    chk_eq("post_rst_duty", int'(bus.duty), 2);

    // Disable at cnt=10 in RUN, then re-enable restarts soft-start
    bus.v_out = 16'sd2500;
    do_period(-1, -1, 2, 4, 2);
    repeat (10) tick();
    bus.en = 1'b0;
    tick();
    chk_eq("dis_state", int'(bus.state), 0);
    chk_eq("dis_duty", int'(bus.duty), 0);
    chk_eq("dis_gate", int'(bus.gate), 0);
    bus.en = 1'b1;
    tick();
    chk_eq("reen_state", int'(bus.state), 1);
    chk_eq("reen_duty", int'(bus.duty), 2);
    do_period(-1, -1, 2, 4, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
